// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0013;
  localparam int          IMEM_DEPTH    = 256;
  localparam int          IMEM_ADDR_W   = 8;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response channel between the fetch stage (master) and the
// instruction memory (slave).
interface imem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/imem_array.sv
// Instruction storage: one write port, registered read port, read-before-write.
// Array contents are never reset; only the read register is.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetches, answers after WAIT_CYCLES wait
// states. Define IMEM_MISALIGN_ERR_EN to flag non-word-aligned fetches as errors.
//
// state | meaning
// IDLE  | ready for a fetch request
// WAIT  | request accepted, wait-state counter running
// RESP  | response presented, held until rsp_ready or flush
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH       = IMEM_DEPTH,
  parameter int          ADDR_W      = IMEM_ADDR_W,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] NOP_WORD    = IMEM_NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  imem_responder_if.slave   bus,
  input  logic              flush,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] rd_addr;
  logic              err_q;
  logic              err_now;
  logic              rsp_err_q;
  logic              accept;
  logic              rd_en;
  logic [31:0]       rd_data;

  assign accept = (state == IDLE) && bus.req_valid && !flush;

`ifdef IMEM_MISALIGN_ERR_EN
  assign err_now = (|bus.req_addr[31:ADDR_W+2]) || (|bus.req_addr[1:0]);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.req_addr[1:0];
  assign err_now = |bus.req_addr[31:ADDR_W+2];
`endif

  // The array read fires on the edge that enters RESP; from IDLE the index
  // has not been latched yet, so it comes straight off the request bus.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = idx_q;
    case (state)
      IDLE: begin
        if (accept) begin
          rd_addr = bus.req_addr[ADDR_W+1:2];
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            rd_en     = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = RESP;
          rd_en     = 1'b1;
        end
      end
      RESP: begin
        if (flush || bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt   <= CNT_INIT;
        idx_q <= bus.req_addr[ADDR_W+1:2];
        err_q <= err_now;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (rd_en) rsp_err_q <= (state == IDLE) ? err_now : err_q;
    end
  end

  imem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we      (ld_we),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_err_q ? NOP_WORD : rd_data;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios plus randomized fetches checked
// against a word-array reference model.
module tb_imem_responder;

  localparam int          DEPTH  = 256;
  localparam int          ADDR_W = 8;
  localparam int          W      = 1;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model_mem [DEPTH];

  imem_responder_if bus ();

  imem_responder #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (W),
    .NOP_WORD    (NOP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .flush   (flush),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_we) model_mem[ld_addr] <= ld_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  task automatic ld(input int i, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = ADDR_W'(i);
    ld_data = d;
    @(negedge clk);
    ld_we   = 1'b0;
  endtask

  task automatic drive_side(input int c, input int flush_at, input int wr_cyc,
                            input int idx, input logic [31:0] wr_data);
    flush   = (c == flush_at);
    ld_we   = (c == wr_cyc);
    ld_addr = ADDR_W'(idx);
    ld_data = wr_data;
  endtask

  // Called and returns at a negedge. c counts clock edges since the accept cycle.
  task automatic fetch(input logic [31:0] addr, input int stall, input int flush_at,
                       input int wr_cyc, input logic [31:0] wr_data);
    int          idx, c, stalled;
    logic        exp_err;
    logic [31:0] snap;
    bit          done, acked;
    idx     = int'((addr >> 2) & 32'(DEPTH - 1));
    exp_err = (addr >= 32'(DEPTH * 4));
`ifdef IMEM_MISALIGN_ERR_EN
    if (addr[1:0] != 2'b00) exp_err = 1'b1;
`endif
    check("idle_ready", 32'(bus.req_ready), 32'd1);
    snap          = model_mem[idx];
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    drive_side(0, flush_at, wr_cyc, idx, wr_data);
    c = 0; stalled = 0; done = 0; acked = 0;
    while (!done) begin
      @(negedge clk);
      c++;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      if (c > 40) begin
        check("timeout", 32'd0, 32'd1);
        done = 1;
      end else if (acked || (flush_at >= 0 && c == flush_at + 1)) begin
        check("back_idle_rdy", 32'(bus.req_ready), 32'd1);
        check("back_idle_vld", 32'(bus.rsp_valid), 32'd0);
        done = 1;
      end else if (c <= W) begin
        check("wait_vld", 32'(bus.rsp_valid), 32'd0);
        check("wait_rdy", 32'(bus.req_ready), 32'd0);
        snap = model_mem[idx];
      end else begin
        check("rsp_vld", 32'(bus.rsp_valid), 32'd1);
        check("rsp_rdy", 32'(bus.req_ready), 32'd0);
        check("rsp_data", bus.rsp_data, exp_err ? NOP : snap);
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        if (stalled < stall) stalled++;
        else begin
          bus.rsp_ready = 1'b1;
          acked = 1;
        end
      end
      if (!done) drive_side(c, flush_at, wr_cyc, idx, wr_data);
    end
    flush         = 1'b0;
    ld_we         = 1'b0;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    ld_we         = 1'b0;
    ld_addr       = '0;
    ld_data       = '0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data",  bus.rsp_data, 32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) ld(i, $urandom);

    // Basic fetch, backpressure, out of range
    ld(3, 32'hDEADBEEF);
    fetch(32'h0000_000C, 0, -1, -1, 32'h0);
    fetch(32'h0000_000C, 5, -1, -1, 32'h0);
    fetch(32'h0000_0400, 0, -1, -1, 32'h0);

    // Flush in WAIT, then a clean fetch; flush together with rsp_ready
    fetch(32'h0000_0008, 0, 1, -1, 32'h0);
    fetch(32'h0000_0004, 0, -1, -1, 32'h0);
    fetch(32'h0000_0004, 0, W + 1, -1, 32'h0);

    // Flush in IDLE blocks acceptance
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0004;
    flush         = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    flush         = 1'b0;
    check("flush_idle_rdy", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    check("flush_idle_vld", 32'(bus.rsp_valid), 32'd0);

    // Load hazards: write before the read, during RESP, and on the read edge
    ld(2, 32'h0);
    fetch(32'h0000_0008, 0, -1, 0, 32'h1111_1111);
    fetch(32'h0000_0008, 2, -1, W + 1, 32'h2222_2222);
    fetch(32'h0000_0008, 0, -1, W, 32'h3333_3333);
    fetch(32'h0000_0008, 0, -1, -1, 32'h0);

    // Misaligned fetch (error only when the option is built in)
    fetch(32'h0000_0006, 0, -1, -1, 32'h0);

    // Asynchronous reset while a response is presented
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0400;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (W) @(negedge clk);
    check("pre_rst_vld",  32'(bus.rsp_valid), 32'd1);
    check("pre_rst_data", bus.rsp_data, NOP);
    #2 reset = 1'b1;
    #1;
    check("async_rst_vld",  32'(bus.rsp_valid), 32'd0);
    check("async_rst_rdy",  32'(bus.req_ready), 32'd1);
    check("async_rst_data", bus.rsp_data, 32'd0);
    check("async_rst_err",  32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Randomized fetches with stalls, flushes and colliding loads
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int          st, fa, wc;
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else                           a = 32'($urandom_range(0, 1023));
      st = int'($urandom_range(0, 3));
      fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W + 1 + st)) : -1;
      wc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W + 1 + st)) : -1;
      fetch(a, st, fa, wc, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory-side end of the fetch interface.
- Accepts word fetch requests from the fetch stage over a valid/ready request channel.
- Returns the instruction word after a programmable wait-state latency over a valid/ready response channel.
- Provides a synchronous program-load write port for the bench/boot loader, plus a flush input that abandons an in-flight fetch when the pipeline redirects on a taken branch.

Parameters:
- DEPTH, 256: number of 32-bit instruction words; power of two.
- ADDR_W, 8: word-index width; equals log2(DEPTH).
- WAIT_CYCLES, 1: extra cycles between request accept and response valid; range 0..15.
- NOP_WORD, 32'h00000013: word returned on error responses (RV32I addi x0,x0,0).

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- req_valid, input, 1: fetch request valid.
- req_ready, output, 1: responder can accept a request.
- req_addr, input, 32: byte address of the instruction.
- rsp_valid, output, 1: response valid.
- rsp_ready, input, 1: fetch stage accepts the response.
- rsp_data, output, 32: instruction word.
- rsp_err, output, 1: address out of range, or misaligned when the option is enabled.
- flush, input, 1: abandon any pending or presented response.
- ld_we, input, 1: program-load write enable.
- ld_addr, input, ADDR_W: program-load word index.
- ld_data, input, 32: program-load data.

Behaviour:
- Reset: clk domain; reset is asynchronous, active-high; clock is clk.
  - Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, wait counter=0.
  - Memory array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && !flush, accept the request and latch the word index req_addr[ADDR_W+1:2].
  - Range error flag = |req_addr[31:ADDR_W+2].
  - If WAIT_CYCLES==0, go to RESP; otherwise load counter=WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; at 0, go to RESP.
- Array read: the array is read on the cycle of entry into RESP, and rsp_data/rsp_err are registered. Error responses drive rsp_data=NOP_WORD.
- Latency: for accept at cycle T, rsp_valid=1 at T+1+WAIT_CYCLES.
- RESP:
  - req_ready=0.
  - rsp_valid, rsp_data and rsp_err are held stable until rsp_ready.
  - On the handshake, return to IDLE; a new request cannot be accepted in the same cycle. Steady-state throughput is one fetch per 2+WAIT_CYCLES cycles.
- flush:
  - In WAIT or RESP: go to IDLE next cycle, deassert rsp_valid, and drop the response.
  - flush wins over a simultaneous rsp_ready.
  - In IDLE: a request presented in the same cycle is not accepted.
- Load port:
  - When ld_we=1, mem[ld_addr] <= ld_data on the clock edge, in any state.
  - A write to the pending address while in WAIT is visible in the response.
  - A write during RESP does not alter the held rsp_data.
  - A write in the same cycle as the RESP-entry read returns old data (read-before-write).
- Reset asserted mid-transaction returns to IDLE immediately with all outputs at reset values; the pending request is lost.

Optional Feature:
- Macro: IMEM_MISALIGN_ERR_EN.
- Defined: req_addr[1:0]!=0 sets the error flag at accept; the response returns NOP_WORD with rsp_err=1.
- Undefined: req_addr[1:0] is ignored; misaligned addresses read the containing word with no error.

Decomposition:
- Shared package imem_pkg:
  - State enum (IDLE/WAIT/RESP).
  - NOP_WORD constant.
  - Default DEPTH/ADDR_W.
- Sub-module imem_array:
  - Single write port, registered read port, read-before-write.
  - Keeps memory inference separate from the FSM.
- Handshake FSM and wait counter stay in imem_responder.

Test Plan:
1. Load mem[3]=32'hDEADBEEF; WAIT_CYCLES=1; request 32'h0000000C at cycle T; rsp_ready=1 → rsp_valid at T+2, rsp_data=DEADBEEF, rsp_err=0; req_ready=1 again at T+3.
2. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → data and valid held stable; release → single handshake, then IDLE.
3. Out of range: req_addr=32'h00000400 (DEPTH=256) → rsp_data=32'h00000013, rsp_err=1.
4. Flush: assert flush in WAIT → no rsp_valid; the next request at 32'h4 returns mem[1] correctly. Also flush concurrent with rsp_ready in RESP → response dropped.
5. Load hazard: write mem[2]=32'h11111111 during WAIT for address 8 → response 11111111. Write mem[2]=32'h22222222 during RESP → held data remains 11111111.
6. Reset during RESP → rsp_valid=0 and req_ready=1 immediately (asynchronous). With IMEM_MISALIGN_ERR_EN, request 32'h00000006 → rsp_err=1, rsp_data=NOP_WORD.
